piece_dispenser: RTL

- Consumer end of the free-running piece randomizer. Samples its 3-bit stream every cycle and accepts only legal piece IDs (1..7).
- In bag mode, enforces a 7-bag: each ID appears once per group of 7.
- Buffers accepted IDs in a short preview queue. Serves them to the game FSM through a req/valid handshake, exposing the current piece and the next piece for the preview display.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/piece_queue.sv | 64 ++++++
 rtl/piece_dispenser.sv | 82 ++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece constants, dispenser state type and bag helper
package tetris_pkg;

  localparam int PIECE_W = 3;

  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_I    = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_J    = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_L    = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_O    = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_S    = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_T    = 3'd6;
  localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd7;

  localparam logic [6:0] BAG_FULL_MASK = 7'h7F;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } disp_state_t;

  // One-hot bag bit for a piece ID; PIECE_NONE maps to no bit.
  function automatic logic [6:0] piece_bit(input logic [PIECE_W-1:0] id);
    if (id == PIECE_NONE) begin
      return 7'd0;
    end
    return 7'd1 << (id - 3'd1);
  endfunction

endpackage

// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - shift-register FIFO holding the current and preview pieces
module piece_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [W-1:0]  entry1,
  output logic [CW-1:0] count
);

  logic [W-1:0]  q     [DEPTH];
  logic [W-1:0]  q_nxt [DEPTH];
  logic [CW-1:0] count_mid;
  logic [CW-1:0] count_nxt;

  // Shift first, then append at the post-shift tail; vacated slots go to zero.
  always_comb begin
    count_mid = count;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_nxt[i] = q[i + 1];
      end
      q_nxt[DEPTH - 1] = '0;
      count_mid = count - CW'(1);
    end
    count_nxt = count_mid;
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_mid) begin
          q_nxt[i] = din;
        end
      end
      count_nxt = count_mid + CW'(1);
    end
  end

  // Queue storage and occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
      count <= count_nxt;
    end
  end

  assign head   = (count != '0)      ? q[0] : '0;
  assign entry1 = (count >= CW'(2))  ? q[1] : '0;

endmodule

// File: rtl/piece_dispenser.sv
// rtl/piece_dispenser.sv - filters randomizer IDs through a 7-bag and serves them to the game FSM
module piece_dispenser
  import tetris_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int BAG_MODE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIECE_W-1:0] random_in,
  input  logic               req,
  output logic [PIECE_W-1:0] piece,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] next_piece,
  output logic               next_valid,
  output logic [2:0]         bag_count
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  disp_state_t   state;
  logic [6:0]    used_mask;
  logic [6:0]    id_bit;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          pop;
  logic          legal;
  logic          fresh;
  logic          accept;

  assign pop    = req && piece_valid;
  assign id_bit = piece_bit(random_in);
  assign legal  = (random_in != PIECE_NONE);
  assign fresh  = (BAG_MODE == 0) || ((used_mask & id_bit) == 7'd0);
  // A full queue can still take a piece when the head leaves on the same edge.
  assign accept = legal && fresh && ((state == ST_FILL) || pop);

  assign count_nxt = count - CW'(pop) + CW'(accept);

  piece_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (PIECE_W)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (accept),
    .pop    (pop),
    .din    (random_in),
    .head   (piece),
    .entry1 (next_piece),
    .count  (count)
  );

  assign piece_valid = (count != '0);
  assign next_valid  = (count >= CW'(2));

  // Fill/full state tracks the occupancy the queue will hold after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= (count_nxt == CW'(QUEUE_DEPTH)) ? ST_FULL : ST_FILL;
    end
  end

  // Bag bookkeeping: mark drawn IDs and start a fresh bag when the seventh lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_mask <= 7'd0;
      bag_count <= 3'd0;
    end else if ((BAG_MODE != 0) && accept) begin
      if ((used_mask | id_bit) == BAG_FULL_MASK) begin
        used_mask <= 7'd0;
        bag_count <= 3'd0;
      end else begin
        used_mask <= used_mask | id_bit;
        bag_count <= bag_count + 3'd1;
      end
    end
  end

endmodule
